// File: rtl/nios_fprint_dma_pkg.sv
// ============================================================================
// Module : nios_fprint_dma_pkg
// Brief  : CSR map, STATUS/CTRL bit positions and FSM encoding for the loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nios_fprint_dma_pkg;

  localparam logic [2:0] c_CSR_SRC    = 3'd0;
  localparam logic [2:0] c_CSR_DST    = 3'd1;
  localparam logic [2:0] c_CSR_LEN    = 3'd2;
  localparam logic [2:0] c_CSR_CTRL   = 3'd3;
  localparam logic [2:0] c_CSR_STATUS = 3'd4;

  localparam int c_CTRL_START  = 0;
  localparam int c_CTRL_IRQ_EN = 1;
  localparam int c_CTRL_ABORT  = 2;

  localparam int c_ST_BUSY    = 0;
  localparam int c_ST_DONE    = 1;
  localparam int c_ST_ERR     = 2;
  localparam int c_ST_ABORTED = 3;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_RUN   = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_ABORT = 2'd3;

  // Member order matches the STATUS register bit layout (busy in bit 0).
  typedef struct packed {
    logic aborted;
    logic err;
    logic done;
    logic busy;
  } status_t;

  function automatic logic [31:0] pack_status(input status_t s);
    return {28'd0, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/nios_fprint_loader_fifo.sv
// ============================================================================
// Module : nios_fprint_loader_fifo
// Brief  : Synchronous word FIFO with occupancy count and single-cycle flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_fprint_loader_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/nios_fprint_scratchpad_loader.sv
// ============================================================================
// Module : nios_fprint_scratchpad_loader
// Brief  : Avalon-MM read DMA that fills the processor scratchpad via a FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_fprint_scratchpad_loader
  import nios_fprint_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SP_AW      = 12,
  parameter int M_AW       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       csr_address,
  input  logic             csr_read,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  output logic [31:0]      csr_readdata,
  output logic [M_AW-1:0]  m_address,
  output logic             m_read,
  input  logic             m_waitrequest,
  input  logic [31:0]      m_readdata,
  input  logic             m_readdatavalid,
  output logic [SP_AW-1:0] sp_address,
  output logic             sp_chipselect,
  output logic             sp_write,
  output logic [3:0]       sp_byteenable,
  output logic [31:0]      sp_writedata,
  output logic             sp_clken,
  output logic             irq
);

  localparam int LW = SP_AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW:0] c_SP_LIMIT = (LW+1)'(1 << SP_AW);
  localparam logic [CW:0] c_CAP      = (CW+1)'(FIFO_DEPTH);

  logic [M_AW-1:0]  r_src;
  logic [SP_AW-1:0] r_dst;
  logic [LW-1:0]    r_len;
  logic             r_irq_en;
  logic             r_done;
  logic             r_err;
  logic             r_aborted;
  logic [31:0]      r_rdata;

  logic [1:0]       r_state;
  logic [M_AW-1:0]  r_addr;
  logic [SP_AW-1:0] r_sp_ptr;
  logic [LW-1:0]    r_job_len;
  logic [LW-1:0]    r_issued;
  logic [LW-1:0]    r_received;
  logic [CW-1:0]    r_inflight;

  logic [CW-1:0]    w_fifo_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [31:0]      w_fifo_data;
  logic [LW:0]      w_end;
  logic [31:0]      w_rdata;
  status_t          w_status;

  logic w_wr_ctrl, w_wr_status, w_start, w_start_err, w_start_zero, w_start_go;
  logic w_active, w_abort, w_accept, w_rdv, w_push, w_finish, w_abort_done;

  assign w_active    = (r_state == c_S_RUN) || (r_state == c_S_DRAIN);
  assign w_wr_ctrl   = csr_write && (csr_address == c_CSR_CTRL);
  assign w_wr_status = csr_write && (csr_address == c_CSR_STATUS);
  assign w_end       = (LW+1)'(r_dst) + (LW+1)'(r_len);

  assign w_start      = w_wr_ctrl && csr_writedata[c_CTRL_START] && (r_state == c_S_IDLE);
  assign w_start_err  = w_start && (w_end > c_SP_LIMIT);
  assign w_start_zero = w_start && !w_start_err && (r_len == '0);
  assign w_start_go   = w_start && !w_start_err && (r_len != '0);
  assign w_abort      = w_wr_ctrl && csr_writedata[c_CTRL_ABORT] && w_active;

  // Issue gate: once in-flight plus buffered words reach the FIFO depth, every
  // outstanding return is guaranteed a slot. That sum only grows on an accepted
  // read, so a stalled request can never lose its qualification.
  assign m_read   = (r_state == c_S_RUN) && (r_issued != r_job_len) && !w_abort &&
                    (({1'b0, r_inflight} + {1'b0, w_fifo_count}) < c_CAP);
  assign w_accept = m_read && !m_waitrequest;
  assign w_rdv    = m_readdatavalid && (r_inflight != '0);
  assign w_push   = w_rdv && w_active;

  assign w_finish     = (r_state == c_S_DRAIN) && (r_received == r_job_len) && w_fifo_empty;
  assign w_abort_done = (r_state == c_S_ABORT) && (r_inflight == '0);

  assign m_address     = r_addr;
  assign sp_write      = w_active && !w_fifo_empty;
  assign sp_chipselect = sp_write;
  assign sp_address    = r_sp_ptr;
  assign sp_writedata  = w_fifo_data;
  assign sp_byteenable = 4'hF;
  assign sp_clken      = 1'b1;
  assign irq           = r_done && r_irq_en;
  assign csr_readdata  = r_rdata;

  nios_fprint_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (r_state == c_S_ABORT),
    .push      (w_push),
    .push_data (m_readdata),
    .pop       (sp_write),
    .pop_data  (w_fifo_data),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_comb begin
    w_status         = '0;
    w_status.busy    = (r_state != c_S_IDLE);
    w_status.done    = r_done;
    w_status.err     = r_err;
    w_status.aborted = r_aborted;
    w_rdata          = '0;
    case (csr_address)
      c_CSR_SRC:    w_rdata = 32'(r_src);
      c_CSR_DST:    w_rdata = 32'(r_dst);
      c_CSR_LEN:    w_rdata = 32'(r_len);
      c_CSR_CTRL:   w_rdata[c_CTRL_IRQ_EN] = r_irq_en;
      c_CSR_STATUS: w_rdata = pack_status(w_status);
      default:      w_rdata = '0;
    endcase
  end

  // Configuration and sticky status. Hardware set beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rdata <= csr_read ? w_rdata : 32'd0;
      if (csr_write) begin
        case (csr_address)
          c_CSR_SRC:  r_src <= {csr_writedata[M_AW-1:2], 2'b00};
          c_CSR_DST:  r_dst <= csr_writedata[SP_AW-1:0];
          c_CSR_LEN:  r_len <= csr_writedata[LW-1:0];
          c_CSR_CTRL: r_irq_en <= csr_writedata[c_CTRL_IRQ_EN];
          default:    ;
        endcase
      end

      if (w_start_zero || w_finish)
        r_done <= 1'b1;
      else if (w_start_go || (w_wr_status && csr_writedata[c_ST_DONE]))
        r_done <= 1'b0;

      if (w_start_err)
        r_err <= 1'b1;
      else if (w_start_go || (w_wr_status && csr_writedata[c_ST_ERR]))
        r_err <= 1'b0;

      if (w_abort_done)
        r_aborted <= 1'b1;
      else if (w_start_go || (w_wr_status && csr_writedata[c_ST_ABORTED]))
        r_aborted <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_addr     <= '0;
      r_sp_ptr   <= '0;
      r_job_len  <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_inflight <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_start_go) begin
            r_state    <= c_S_RUN;
            r_addr     <= r_src;
            r_sp_ptr   <= r_dst;
            r_job_len  <= r_len;
            r_issued   <= '0;
            r_received <= '0;
          end
        end
        c_S_RUN: begin
          if (w_abort)                     r_state <= c_S_ABORT;
          else if (r_issued == r_job_len)  r_state <= c_S_DRAIN;
        end
        c_S_DRAIN: begin
          if (w_abort)       r_state <= c_S_ABORT;
          else if (w_finish) r_state <= c_S_IDLE;
        end
        c_S_ABORT: begin
          if (w_abort_done) r_state <= c_S_IDLE;
        end
        default: r_state <= c_S_IDLE;
      endcase

      if (w_accept) begin
        r_addr   <= r_addr + M_AW'(4);
        r_issued <= r_issued + LW'(1);
      end
      if (w_push)   r_received <= r_received + LW'(1);
      if (sp_write) r_sp_ptr   <= r_sp_ptr + SP_AW'(1);

      case ({w_accept, w_rdv})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A return with nothing outstanding is a bus protocol violation.
  a_rdv_has_inflight: assert property (@(posedge clk) disable iff (reset)
    m_readdatavalid |-> (r_inflight != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_nios_fprint_scratchpad_loader.sv
// ============================================================================
// Module : tb_nios_fprint_scratchpad_loader
// Brief  : Directed bench with a latency-configurable memory and scratchpad model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nios_fprint_scratchpad_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic [31:0] m_address;
  logic        m_read, m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata;
  logic [11:0] sp_address;
  logic        sp_chipselect, sp_write, sp_clken, irq;
  logic [3:0]  sp_byteenable;
  logic [31:0] sp_writedata;

  int total = 0;
  int bad   = 0;

  int          lat = 1;
  bit          wr_random = 1'b0;
  int          cyc = 0;
  int          accepted = 0;
  int          sp_count = 0;
  int          stall_viol = 0;
  int          mon_err = 0;
  logic [11:0] last_sp;
  logic [31:0] sp_mem [4096];
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;

  nios_fprint_scratchpad_loader dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .sp_address(sp_address), .sp_chipselect(sp_chipselect), .sp_write(sp_write),
    .sp_byteenable(sp_byteenable), .sp_writedata(sp_writedata),
    .sp_clken(sp_clken), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory and scratchpad model: runs 2 time units after each falling edge.
  initial begin
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    forever begin
      @(posedge clk); #7; cyc++;
      if (prev_stall && (m_read !== 1'b1 || m_address !== prev_addr)) stall_viol++;
      if (sp_write === 1'b1) begin
        sp_mem[sp_address] = sp_writedata; sp_count++; last_sp = sp_address;
      end
      if (sp_chipselect !== sp_write || sp_byteenable !== 4'hF || sp_clken !== 1'b1) mon_err++;
      m_waitrequest = wr_random ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_read === 1'b1 && !m_waitrequest) begin
        pend_addr.push_back(m_address); pend_due.push_back(cyc + lat); accepted++;
      end
      prev_stall = (m_read === 1'b1) && m_waitrequest;
      prev_addr  = m_address;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        m_readdatavalid = 1'b1; m_readdata = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        m_readdatavalid = 1'b0; m_readdata = 32'd0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk); csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); csr_address = a; csr_read = 1'b1;
    @(negedge clk); csr_read = 1'b0; d = csr_readdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n = 0;
    do begin csr_rd(3'd4, s); n++; end while (s[0] && n < 3000);
    total++;
    if (s[0] !== 1'b0) begin bad++; $display("FAIL %s idle: busy still %0d after %0d polls, want 0", name, s[0], n); end
  endtask

  task automatic clear_sp();
    for (int i = 0; i < 4096; i++) sp_mem[i] = 32'hDEADBEEF;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    total++; if (csr_readdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", csr_readdata); end
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL rst_m_read: got %b want 0", m_read); end
    total++; if (sp_write !== 1'b0 || sp_chipselect !== 1'b0) begin bad++; $display("FAIL rst_sp: got wr=%b cs=%b want 0", sp_write, sp_chipselect); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    csr_rd(3'd4, s);
    total++; if (s !== 32'd0) begin bad++; $display("FAIL rst_status: got %h want 0", s); end
    csr_rd(3'd0, s);
    total++; if (s !== 32'd0) begin bad++; $display("FAIL rst_src: got %h want 0", s); end
    csr_rd(3'd2, s);
    total++; if (s !== 32'd0) begin bad++; $display("FAIL rst_len: got %h want 0", s); end
  endtask

  task automatic test_basic();
    logic [31:0] s;
    int ba, bs;
    clear_sp(); lat = 1;
    csr_wr(3'd0, 32'h0000_1003);
    csr_rd(3'd0, s);
    total++; if (s !== 32'h0000_1000) begin bad++; $display("FAIL src_lsb: got %h want 00001000", s); end
    csr_wr(3'd1, 32'd0); csr_wr(3'd2, 32'd4);
    ba = accepted; bs = sp_count;
    csr_wr(3'd3, 32'h3);
    csr_rd(3'd4, s);
    total++; if (s[0] !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", s[0]); end
    wait_idle("basic");
    csr_rd(3'd4, s);
    total++; if (s !== 32'h2) begin bad++; $display("FAIL basic_status: got %h want 2", s); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b want 1", irq); end
    total++; if (accepted - ba !== 4) begin bad++; $display("FAIL basic_reads: got %0d want 4", accepted - ba); end
    total++; if (sp_count - bs !== 4) begin bad++; $display("FAIL basic_writes: got %0d want 4", sp_count - bs); end
    total++; if (sp_mem[0] !== 32'h4A5A_1000) begin bad++; $display("FAIL basic_w0: got %h want 4a5a1000", sp_mem[0]); end
    for (int k = 1; k < 4; k++) begin
      total++; if (sp_mem[k] !== mem_word(32'h1000 + 32'(4*k))) begin bad++; $display("FAIL basic_w%0d: got %h want %h", k, sp_mem[k], mem_word(32'h1000 + 32'(4*k))); end
    end
    csr_wr(3'd4, 32'h2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
    csr_rd(3'd4, s);
    total++; if (s !== 32'h0) begin bad++; $display("FAIL w1c_status: got %h want 0", s); end
  endtask

  task automatic test_backpressure();
    logic [31:0] s;
    int ba, bs;
    clear_sp(); lat = 20;
    csr_wr(3'd0, 32'h2000); csr_wr(3'd1, 32'd100); csr_wr(3'd2, 32'd32);
    ba = accepted; bs = sp_count;
    csr_wr(3'd3, 32'h3);
    repeat (12) @(negedge clk);
    total++; if (accepted - ba !== 8) begin bad++; $display("FAIL bp_cap: got %0d reads want 8", accepted - ba); end
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL bp_stall: got m_read=%b want 0", m_read); end
    csr_wr(3'd2, 32'd5);
    csr_wr(3'd3, 32'h3);
    wait_idle("bp");
    total++; if (accepted - ba !== 32) begin bad++; $display("FAIL bp_reads: got %0d want 32", accepted - ba); end
    total++; if (sp_count - bs !== 32) begin bad++; $display("FAIL bp_writes: got %0d want 32", sp_count - bs); end
    for (int k = 0; k < 32; k++) begin
      total++; if (sp_mem[100+k] !== mem_word(32'h2000 + 32'(4*k))) begin bad++; $display("FAIL bp_w%0d: got %h want %h", k, sp_mem[100+k], mem_word(32'h2000 + 32'(4*k))); end
    end
    csr_rd(3'd2, s);
    total++; if (s !== 32'd5) begin bad++; $display("FAIL bp_len_store: got %0d want 5", s); end
    lat = 1;
  endtask

  task automatic test_bounds();
    logic [31:0] s;
    int ba, bs;
    clear_sp(); lat = 1;
    csr_wr(3'd4, 32'hE);
    csr_wr(3'd0, 32'h3000); csr_wr(3'd1, 32'd4090); csr_wr(3'd2, 32'd7);
    ba = accepted; bs = sp_count;
    csr_wr(3'd3, 32'h3);
    repeat (5) @(negedge clk);
    csr_rd(3'd4, s);
    total++; if (s !== 32'h4) begin bad++; $display("FAIL bnd_err: got %h want 4", s); end
    total++; if (accepted - ba !== 0 || sp_count - bs !== 0) begin bad++; $display("FAIL bnd_quiet: got reads=%0d writes=%0d want 0", accepted - ba, sp_count - bs); end
    csr_wr(3'd2, 32'd6);
    csr_wr(3'd3, 32'h3);
    wait_idle("bnd");
    csr_rd(3'd4, s);
    total++; if (s !== 32'h2) begin bad++; $display("FAIL bnd_status: got %h want 2", s); end
    total++; if (last_sp !== 12'd4095) begin bad++; $display("FAIL bnd_last: got %0d want 4095", last_sp); end
    total++; if (sp_count - bs !== 6) begin bad++; $display("FAIL bnd_writes: got %0d want 6", sp_count - bs); end
    total++; if (sp_mem[4095] !== mem_word(32'h3014)) begin bad++; $display("FAIL bnd_lastword: got %h want %h", sp_mem[4095], mem_word(32'h3014)); end
  endtask

  task automatic test_random_wait();
    logic [31:0] s;
    int bs;
    clear_sp(); lat = 3; stall_viol = 0; wr_random = 1'b1;
    csr_wr(3'd0, 32'h8000); csr_wr(3'd1, 32'd200); csr_wr(3'd2, 32'd20);
    bs = sp_count;
    csr_wr(3'd3, 32'h3);
    wait_idle("rnd");
    wr_random = 1'b0;
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL rnd_hold: got %0d unstable stalls want 0", stall_viol); end
    total++; if (sp_count - bs !== 20) begin bad++; $display("FAIL rnd_writes: got %0d want 20", sp_count - bs); end
    for (int k = 0; k < 20; k++) begin
      total++; if (sp_mem[200+k] !== mem_word(32'h8000 + 32'(4*k))) begin bad++; $display("FAIL rnd_w%0d: got %h want %h", k, sp_mem[200+k], mem_word(32'h8000 + 32'(4*k))); end
    end
    csr_rd(3'd4, s);
    total++; if (s !== 32'h2) begin bad++; $display("FAIL rnd_status: got %h want 2", s); end
    lat = 1;
  endtask

  task automatic test_abort();
    logic [31:0] s;
    int ba, bs, snap, n;
    clear_sp(); lat = 4;
    csr_wr(3'd0, 32'h4000); csr_wr(3'd1, 32'd300); csr_wr(3'd2, 32'd64);
    ba = accepted;
    csr_wr(3'd3, 32'h3);
    n = 0;
    while (accepted - ba < 10 && n < 200) begin @(negedge clk); n++; end
    total++; if (accepted - ba < 10) begin bad++; $display("FAIL abt_issue: got %0d reads want >=10", accepted - ba); end
    csr_address = 3'd3; csr_writedata = 32'h6; csr_write = 1'b1; snap = accepted;
    @(negedge clk); csr_write = 1'b0;
    wait_idle("abt");
    total++; if (accepted !== snap) begin bad++; $display("FAIL abt_noissue: got %0d reads want %0d", accepted, snap); end
    total++; if (pend_addr.size() !== 0) begin bad++; $display("FAIL abt_drain: got %0d outstanding want 0", pend_addr.size()); end
    csr_rd(3'd4, s);
    total++; if (s !== 32'h8) begin bad++; $display("FAIL abt_status: got %h want 8", s); end
    total++; if (irq !== 1'b0 || m_read !== 1'b0) begin bad++; $display("FAIL abt_quiet: got irq=%b m_read=%b want 0", irq, m_read); end
    clear_sp(); lat = 1;
    csr_wr(3'd0, 32'h5000); csr_wr(3'd1, 32'd400); csr_wr(3'd2, 32'd2);
    bs = sp_count;
    csr_wr(3'd3, 32'h3);
    wait_idle("abt_next");
    total++; if (sp_count - bs !== 2) begin bad++; $display("FAIL abt_next_writes: got %0d want 2", sp_count - bs); end
    total++; if (sp_mem[400] !== mem_word(32'h5000) || sp_mem[401] !== mem_word(32'h5004)) begin bad++; $display("FAIL abt_next_data: got %h %h want %h %h", sp_mem[400], sp_mem[401], mem_word(32'h5000), mem_word(32'h5004)); end
  endtask

  task automatic test_len0_w1c();
    logic [31:0] s;
    int ba, bs, n;
    bit seen;
    csr_wr(3'd4, 32'hE); csr_wr(3'd2, 32'd0);
    ba = accepted; bs = sp_count;
    @(negedge clk); csr_address = 3'd3; csr_writedata = 32'h3; csr_write = 1'b1;
    @(negedge clk); csr_write = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL len0_next: got irq=%b want 1", irq); end
    csr_rd(3'd4, s);
    total++; if (s !== 32'h2) begin bad++; $display("FAIL len0_status: got %h want 2", s); end
    total++; if (accepted - ba !== 0 || sp_count - bs !== 0) begin bad++; $display("FAIL len0_quiet: got reads=%0d writes=%0d want 0", accepted - ba, sp_count - bs); end
    csr_wr(3'd0, 32'h6000); csr_wr(3'd1, 32'd500); csr_wr(3'd2, 32'd1);
    @(negedge clk); csr_address = 3'd3; csr_writedata = 32'h3; csr_write = 1'b1;
    @(negedge clk); csr_address = 3'd4; csr_writedata = 32'h2;
    seen = 1'b0; n = 0;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      if (irq === 1'b1) seen = 1'b1;
    end
    csr_write = 1'b0;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL setwins_irq: got done never set want set"); end
    csr_rd(3'd4, s);
    total++; if (s !== 32'h2) begin bad++; $display("FAIL setwins_status: got %h want 2", s); end
    total++; if (mon_err !== 0) begin bad++; $display("FAIL sp_port_static: got %0d bad cycles want 0", mon_err); end
  endtask

  initial begin
    reset = 1'b1; csr_address = 3'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bounds();
    test_random_wait();
    test_abort();
    test_len0_w1c();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
